// File: rtl/fft_to_bram_pkg.sv
// Shared FFT stream constants: frame length, tdata field positions, and per-beat frame flags.
// Also used by the BRAM-to-FFT sender, so the field layout stays the same on both sides.
package fft_to_bram_pkg;

    localparam int LOG2_N_DEF = 12;
    localparam int FRAME_LEN  = 1 << LOG2_N_DEF;
    localparam int OUT_W_DEF  = 16;

    localparam int TDATA_W = 32;
    localparam int RE_LSB  = 0;
    localparam int RE_MSB  = 15;
    localparam int IM_LSB  = 16;
    localparam int IM_MSB  = 31;

    typedef struct packed {
        logic done;
        logic missing;
        logic unexpected;
    } frame_flags_t;

endpackage

// File: rtl/fft_to_bram_if.sv
// FFT AXI-stream input plus BRAM write port. The slave side is the converter; the master side is the FFT core and the BRAM.
// Stream flow control: fft_tready is driven by the converter and follows enable.
interface fft_to_bram_if
    import fft_to_bram_pkg::*;
#(
    parameter int LOG2_N = LOG2_N_DEF,
    parameter int OUT_W  = OUT_W_DEF
);

    logic [TDATA_W-1:0] fft_tdata;
    logic               fft_tvalid;
    logic               fft_tlast;
    logic               fft_tready;
    logic               enable;
    logic [LOG2_N-1:0]  addr;
    logic [OUT_W-1:0]   wdata;
    logic               we;
    logic               frame_done;
    logic               last_missing;
    logic               last_unexpected;
    logic [7:0]         frame_count;

    modport slave (
        input  fft_tdata, fft_tvalid, fft_tlast, enable,
        output fft_tready, addr, wdata, we, frame_done, last_missing,
               last_unexpected, frame_count
    );

    modport master (
        output fft_tdata, fft_tvalid, fft_tlast, enable,
        input  fft_tready, addr, wdata, we, frame_done, last_missing,
               last_unexpected, frame_count
    );

endinterface

// File: rtl/fft_to_bram_cplx_power.sv
// Two-stage pipelined re^2+im^2. Each result leaves with its tag 2 cycles after entry.
// Backpressure: none; the pipeline accepts a new input every cycle.
module fft_to_bram_cplx_power #(
    parameter int TAG_W = 1,
    parameter int OUT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_vld,
    input  logic signed [15:0]  i_re,
    input  logic signed [15:0]  i_im,
    input  logic [TAG_W-1:0]    i_tag,
    output logic                o_vld,
    output logic [OUT_W-1:0]    o_pwr,
    output logic [TAG_W-1:0]    o_tag
);

    logic signed [31:0] w_re_x;
    logic signed [31:0] w_im_x;

    logic               r_s1_vld;
    logic [31:0]        r_re_sq;
    logic [31:0]        r_im_sq;
    logic [TAG_W-1:0]   r_s1_tag;

    logic               r_s2_vld;
    logic [OUT_W-1:0]   r_pwr;
    logic [TAG_W-1:0]   r_s2_tag;

    assign w_re_x = 32'(i_re);
    assign w_im_x = 32'(i_im);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_re_sq  <= '0;
            r_im_sq  <= '0;
            r_s1_tag <= '0;
        end else begin
            r_s1_vld <= i_vld;
            if (i_vld) begin
                r_re_sq  <= $unsigned(w_re_x * w_re_x);
                r_im_sq  <= $unsigned(w_im_x * w_im_x);
                r_s1_tag <= i_tag;
            end
        end
    end

    // Each square is at most 2^30, so the 32-bit sum cannot overflow; keep only the top OUT_W bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld <= 1'b0;
            r_pwr    <= '0;
            r_s2_tag <= '0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_pwr    <= OUT_W'((r_re_sq + r_im_sq) >> (32 - OUT_W));
                r_s2_tag <= r_s1_tag;
            end
        end
    end

    assign o_vld = r_s2_vld;
    assign o_pwr = r_pwr;
    assign o_tag = r_s2_tag;

endmodule

// File: rtl/fft_to_bram.sv
// Writes FFT bins to BRAM as scaled power, checks frame length against tlast, and counts frames.
// Latency: accept to we is 2 cycles. Backpressure: fft_tready = enable; writes already in flight always finish.
module fft_to_bram
    import fft_to_bram_pkg::*;
#(
    parameter int LOG2_N = LOG2_N_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    fft_to_bram_if.slave  io_bus
);

    localparam int FLAG_W = $bits(frame_flags_t);
    localparam int TAG_W  = LOG2_N + FLAG_W;

    logic               w_ready;
    logic               w_accept;
    logic               w_at_last;
    frame_flags_t       w_flags;
    logic [TAG_W-1:0]   w_tag;

    logic               w_out_vld;
    logic [OUT_W-1:0]   w_out_pwr;
    logic [TAG_W-1:0]   w_out_tag;
    frame_flags_t       w_out_flags;

    logic [LOG2_N-1:0]  r_bin;
    logic               r_done_s1;
    logic [7:0]         r_frame_count;

    assign w_ready   = io_bus.enable & ~rst;
    assign w_accept  = io_bus.fft_tvalid & w_ready;
    assign w_at_last = (r_bin == '1);

    // The frame ends at whichever comes first: bin N-1 or tlast.
    always_comb begin
        w_flags            = '0;
        w_flags.done       = w_at_last | io_bus.fft_tlast;
        w_flags.missing    = w_at_last & ~io_bus.fft_tlast;
        w_flags.unexpected = ~w_at_last & io_bus.fft_tlast;
    end

    assign w_tag = {r_bin, w_flags};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin <= '0;
        end else if (w_accept) begin
            r_bin <= w_flags.done ? '0 : r_bin + LOG2_N'(1);
        end
    end

    // frame_count steps on the same edge that raises we for the frame's last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_s1     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_done_s1 <= w_accept & w_flags.done;
            if (r_done_s1) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    fft_to_bram_cplx_power #(
        .TAG_W (TAG_W),
        .OUT_W (OUT_W)
    ) u_cplx_power (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_accept),
        .i_re  (io_bus.fft_tdata[RE_MSB:RE_LSB]),
        .i_im  (io_bus.fft_tdata[IM_MSB:IM_LSB]),
        .i_tag (w_tag),
        .o_vld (w_out_vld),
        .o_pwr (w_out_pwr),
        .o_tag (w_out_tag)
    );

    assign w_out_flags = frame_flags_t'(w_out_tag[FLAG_W-1:0]);

    assign io_bus.fft_tready      = w_ready;
    assign io_bus.we              = w_out_vld;
    assign io_bus.addr            = w_out_tag[TAG_W-1 -: LOG2_N];
    assign io_bus.wdata           = w_out_pwr;
    assign io_bus.frame_done      = w_out_vld & w_out_flags.done;
    assign io_bus.last_missing    = w_out_vld & w_out_flags.missing;
    assign io_bus.last_unexpected = w_out_vld & w_out_flags.unexpected;
    assign io_bus.frame_count     = r_frame_count;

endmodule

// File: tb/tb_fft_to_bram.sv
// Directed bench for fft_to_bram: a cycle table for latency and flags, then full-frame, tlast-error, stall and reset sequences.
module tb_fft_to_bram;
    import fft_to_bram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_to_bram_if bus ();

    fft_to_bram dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned addr;
        int unsigned wdata;
        logic        done;
        logic        miss;
        logic        unexp;
        int          cyc;
    } wr_t;

    wr_t wr_q[$];
    int  cyc   = 0;
    int  stray = 0;

    // Every write seen at the falling edge, plus any flag pulse that shows up without we.
    always @(negedge clk) begin
        wr_t w;
        cyc = cyc + 1;
        if (bus.we === 1'b1) begin
            w.addr  = bus.addr;
            w.wdata = bus.wdata;
            w.done  = bus.frame_done;
            w.miss  = bus.last_missing;
            w.unexp = bus.last_unexpected;
            w.cyc   = cyc;
            wr_q.push_back(w);
        end else if (bus.frame_done !== 1'b0 || bus.last_missing !== 1'b0 ||
                     bus.last_unexpected !== 1'b0) begin
            stray = stray + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic v, input logic [15:0] re, input logic [15:0] im,
                        input logic last, input logic en);
        bus.fft_tvalid = v;
        bus.fft_tdata  = {im, re};
        bus.fft_tlast  = last;
        bus.enable     = en;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) beat(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    endtask

    task automatic stream(input int first, input int count, input int last_at);
        for (int k = 0; k < count; k++)
            beat(1'b1, 16'(first + k), 16'd0, (first + k) == last_at, 1'b1);
    endtask

    task automatic do_reset();
        #2;
        rst            = 1'b1;
        bus.fft_tvalid = 1'b0;
        bus.fft_tlast  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Writes base..base+n-1 must be bins first..first+n-1 carrying (re^2)>>16 with re = bin.
    function automatic int seq_bad(input int base, input int first, input int n);
        int bad = 0;
        for (int j = 0; j < n; j++) begin
            int unsigned b = first + j;
            if (wr_q[base + j].addr != b || wr_q[base + j].wdata != ((b * b) >> 16))
                bad = bad + 1;
        end
        return bad;
    endfunction

    typedef struct {
        logic        v, en, last;
        logic [15:0] re, im;
        logic        e_we;
        logic [11:0] e_addr;
        logic [15:0] e_wd;
        logic [2:0]  e_fl;
        logic [7:0]  e_fc;
    } vec_t;

    vec_t vec[13];

    initial begin
        int base, bad, n;

        // Expected outputs are the values seen after each row's clock edge; beat results appear on the following row.
        vec[0]  = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 12'd0, 16'h0000, 3'b000, 8'd0};
        vec[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'hFE00, 1'b1, 12'd0, 16'h0001, 3'b000, 8'd0};
        vec[2]  = '{1'b0, 1'b1, 1'b0, 16'h0007, 16'h0007, 1'b1, 12'd1, 16'h0004, 3'b000, 8'd0};
        vec[3]  = '{1'b1, 1'b1, 1'b0, 16'h8000, 16'h8000, 1'b0, 12'd0, 16'h0000, 3'b000, 8'd0};
        vec[4]  = '{1'b1, 1'b0, 1'b0, 16'h0400, 16'h0400, 1'b1, 12'd2, 16'h8000, 3'b000, 8'd0};
        vec[5]  = '{1'b1, 1'b1, 1'b0, 16'h0400, 16'h0400, 1'b0, 12'd0, 16'h0000, 3'b000, 8'd0};
        vec[6]  = '{1'b1, 1'b1, 1'b0, 16'h7FFF, 16'h7FFF, 1'b1, 12'd3, 16'h0020, 3'b000, 8'd0};
        vec[7]  = '{1'b1, 1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1, 12'd4, 16'h7FFE, 3'b000, 8'd0};
        vec[8]  = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 12'd5, 16'h4000, 3'b000, 8'd0};
        vec[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 12'd6, 16'h0000, 3'b101, 8'd1};
        vec[10] = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 12'd0, 16'h0000, 3'b000, 8'd1};
        vec[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 12'd0, 16'h0001, 3'b000, 8'd1};
        vec[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 12'd0, 16'h0000, 3'b000, 8'd1};

        bus.fft_tvalid = 1'b0;
        bus.fft_tdata  = '0;
        bus.fft_tlast  = 1'b0;
        bus.enable     = 1'b1;
        #3;
        chk("reset_tready", 32'(bus.fft_tready), 32'd0);
        chk("reset_we", 32'(bus.we), 32'd0);
        chk("reset_addr_wdata", {4'd0, bus.addr, bus.wdata}, 32'd0);
        chk("reset_flags", {29'd0, bus.frame_done, bus.last_missing, bus.last_unexpected}, 32'd0);
        chk("reset_frame_count", 32'(bus.frame_count), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            bus.fft_tvalid = vec[i].v;
            bus.fft_tdata  = {vec[i].im, vec[i].re};
            bus.fft_tlast  = vec[i].last;
            bus.enable     = vec[i].en;
            #1;
            chk($sformatf("vec%0d_tready", i), 32'(bus.fft_tready), 32'(vec[i].en));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_we", i), 32'(bus.we), 32'(vec[i].e_we));
            if (vec[i].e_we) begin
                chk($sformatf("vec%0d_addr", i), 32'(bus.addr), 32'(vec[i].e_addr));
                chk($sformatf("vec%0d_wdata", i), 32'(bus.wdata), 32'(vec[i].e_wd));
            end
            chk($sformatf("vec%0d_flags", i),
                {29'd0, bus.frame_done, bus.last_missing, bus.last_unexpected}, 32'(vec[i].e_fl));
            chk($sformatf("vec%0d_frame_count", i), 32'(bus.frame_count), 32'(vec[i].e_fc));
        end

        // Full frame with tlast on the last bin.
        do_reset();
        base = wr_q.size();
        stream(0, FRAME_LEN, FRAME_LEN - 1);
        idle(3);
        chk("fullA_count", 32'(wr_q.size() - base), 32'(FRAME_LEN));
        if (wr_q.size() - base == FRAME_LEN) begin
            bad = seq_bad(base, 0, FRAME_LEN);
            for (int j = 0; j < FRAME_LEN; j++)
                if (wr_q[base + j].done != (j == FRAME_LEN - 1) || wr_q[base + j].miss || wr_q[base + j].unexp)
                    bad = bad + 1;
            chk("fullA_bad_writes", 32'(bad), 32'd0);
        end
        chk("fullA_frame_count", 32'(bus.frame_count), 32'd1);

        // tlast early on bin 99, then the counter restarts at 0.
        do_reset();
        base = wr_q.size();
        stream(0, 100, 99);
        beat(1'b1, 16'h0100, 16'h0000, 1'b0, 1'b1);
        idle(3);
        chk("early_count", 32'(wr_q.size() - base), 32'd101);
        if (wr_q.size() - base == 101) begin
            chk("early_bin99_addr", wr_q[base + 99].addr, 32'd99);
            chk("early_bin99_flags", {29'd0, wr_q[base + 99].done, wr_q[base + 99].miss, wr_q[base + 99].unexp}, 32'b101);
            chk("early_next_addr", wr_q[base + 100].addr, 32'd0);
            chk("early_next_wdata", wr_q[base + 100].wdata, 32'd1);
        end
        chk("early_frame_count", 32'(bus.frame_count), 32'd1);

        // No tlast at all: the count closes the frame, and bin N-1 and bin 0 are written on back-to-back cycles.
        do_reset();
        base = wr_q.size();
        stream(0, FRAME_LEN + 1, -1);
        idle(3);
        chk("miss_count", 32'(wr_q.size() - base), 32'(FRAME_LEN + 1));
        if (wr_q.size() - base == FRAME_LEN + 1) begin
            n = base + FRAME_LEN - 1;
            chk("miss_last_addr", wr_q[n].addr, 32'(FRAME_LEN - 1));
            chk("miss_last_flags", {29'd0, wr_q[n].done, wr_q[n].miss, wr_q[n].unexp}, 32'b110);
            chk("miss_wrap_addr", wr_q[n + 1].addr, 32'd0);
            chk("miss_wrap_flags", {29'd0, wr_q[n + 1].done, wr_q[n + 1].miss, wr_q[n + 1].unexp}, 32'b000);
            chk("miss_wrap_wdata", wr_q[n + 1].wdata, 32'd256);
            chk("miss_back_to_back", 32'(wr_q[n + 1].cyc - wr_q[n].cyc), 32'd1);
        end
        chk("miss_frame_count", 32'(bus.frame_count), 32'd1);

        // Five stall cycles at bin 2000 while valid stays high.
        do_reset();
        base = wr_q.size();
        stream(0, 2000, -1);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            bus.fft_tvalid = 1'b1;
            bus.fft_tdata  = {16'd0, 16'd2000};
            bus.fft_tlast  = 1'b0;
            bus.enable     = 1'b0;
            #1;
            if (bus.fft_tready !== 1'b0) bad = bad + 1;
            @(posedge clk);
            @(negedge clk);
        end
        chk("stall_tready_high", 32'(bad), 32'd0);
        chk("stall_pending_done", 32'(wr_q.size() - base), 32'd2000);
        stream(2000, 10, -1);
        idle(3);
        chk("stall_count", 32'(wr_q.size() - base), 32'd2010);
        if (wr_q.size() - base == 2010) begin
            chk("stall_resume_addr", wr_q[base + 2000].addr, 32'd2000);
            chk("stall_seq_bad", 32'(seq_bad(base, 0, 2010)), 32'd0);
        end

        // Reset with bins 1500 and 1501 still in the pipeline.
        do_reset();
        stream(0, 1502, -1);
        chk("rstmid_we_before", 32'(bus.we), 32'd1);
        chk("rstmid_addr_before", 32'(bus.addr), 32'd1500);
        bus.fft_tvalid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_we", 32'(bus.we), 32'd0);
        chk("rstmid_addr_wdata", {4'd0, bus.addr, bus.wdata}, 32'd0);
        chk("rstmid_tready", 32'(bus.fft_tready), 32'd0);
        n = wr_q.size();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(3);
        chk("rstmid_no_writes", 32'(wr_q.size() - n), 32'd0);
        beat(1'b1, 16'h0100, 16'h0000, 1'b0, 1'b1);
        idle(3);
        chk("rstmid_next_count", 32'(wr_q.size() - n), 32'd1);
        if (wr_q.size() - n == 1) begin
            chk("rstmid_next_addr", wr_q[n].addr, 32'd0);
            chk("rstmid_next_wdata", wr_q[n].wdata, 32'd1);
        end

        chk("stray_flag_pulses", 32'(stray), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_to_bram.md
FFT_TO_BRAM -- requirements
Module: fft_to_bram

Interface
REQ-001 Parameter LOG2_N, default 12, meaning log2 of FFT frame length (N = 4096 bins).
REQ-002 Parameter OUT_W, default 16, meaning width of each stored magnitude word.
REQ-003 Ports, one per line (name, direction, width, meaning); one clock; reset is asynchronous and active-high:
- clk  in  1  sole clock
- rst  in  1  asynchronous active-high reset
- fft_tdata  in  32  AXI-stream beat {im[31:16], re[15:0]}, both two's complement
- fft_tvalid  in  1  beat valid
- fft_tlast  in  1  core's end-of-frame marker
- fft_tready  out  1  block accepts beat
- enable  in  1  0 = stall input (fft_tready low)
- addr  out  LOG2_N  BRAM write address (bin index)
- wdata  out  OUT_W  BRAM write data (scaled power)
- we  out  1  BRAM write strobe
- frame_done  out  1  one-cycle pulse, frame fully written
- last_missing  out  1  one-cycle pulse, bin N-1 arrived without tlast
- last_unexpected  out  1  one-cycle pulse, tlast arrived before bin N-1
- frame_count  out  8  completed frames, wraps 255 -> 0

Function
REQ-004 fft_tready SHALL equal enable combinationally, forced 0 while rst is high.
REQ-005 A beat is accepted in a cycle with fft_tvalid and fft_tready both high; no other cycle SHALL alter the bin counter.
REQ-006 Stage 1, on accept: register re*re and im*im as 32-bit unsigned products, capture current bin index and a valid bit.
REQ-007 Stage 2: sum the products to 32-bit power (max 2^31, no overflow); register wdata = power[31:32-OUT_W], addr = captured index, we = stage-1 valid.
REQ-008 Latency: beat accepted at cycle T SHALL produce we=1 at cycle T+2 with its addr/wdata; throughput one beat per cycle, no bubbles.
REQ-009 Bin counter: LOG2_N bits, reset 0, increments on each accepted beat, wraps N-1 -> 0.
REQ-010 Accepted beat at index N-1 with tlast=1: normal frame end; counter -> 0.
REQ-011 Accepted beat at index N-1 with tlast=0: last_missing pulses; counter still wraps to 0 (frame boundary enforced by count).
REQ-012 Accepted beat at index < N-1 with tlast=1: beat is written, last_unexpected pulses, counter -> 0.
REQ-013 frame_done SHALL pulse and frame_count SHALL increment aligned with the we of the frame's final beat (cycle T+2) in all cases REQ-010..012.
REQ-014 Error and done pulses SHALL be delayed through the pipeline with their beat so all three flags align with the corresponding we.
REQ-015 Deasserting enable mid-frame SHALL only stall: counter holds, in-flight pipeline beats still complete their writes.
REQ-016 Simultaneous accept every cycle across a frame boundary SHALL write bin N-1 then bin 0 on consecutive cycles.

Reset
REQ-017 rst high SHALL immediately clear: counter, pipeline valids, we, frame_done, last_missing, last_unexpected, frame_count, addr, wdata (all 0).
REQ-018 Reset mid-frame SHALL discard in-flight beats (no write after release) and the next accepted beat SHALL be bin 0.

Structure
REQ-019 Shared package holds LOG2_N default, frame length, and the {im,re} tdata field positions, shared with the BRAM-to-FFT sender.
REQ-020 One sub-module natural: cplx_power (two-stage pipelined re^2+im^2), instantiated once.

Verification
REQ-021 4096 beats re=i, im=0, tlast on last -> writes addr i, wdata=(i*i)>>16, one frame_done, no error flags, frame_count=1.
REQ-022 Beat re=-32768, im=-32768 -> wdata=16'h8000 at T+2.
REQ-023 tlast on beat 99 -> last_unexpected pulse with write to addr 99; next beat written to addr 0.
REQ-024 4096 beats with no tlast -> last_missing and frame_done pulse with addr 4095; following beat at addr 0.
REQ-025 enable low for 5 cycles mid-frame at bin 2000 -> fft_tready low, pending writes complete, resume at addr 2000 with no skip.
REQ-026 rst asserted at bin 1500 with 2 beats in flight -> we=0 immediately, no writes after release, next write to addr 0.
